// File: rtl/babbage_arbiter.sv
// Two-requester front end for the difference engine: grants one job at a time,
// launches it, and returns the result, or an error pulse if the engine stalls.
module babbage_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [28:0] req0_coef,
    input  logic [28:0] req1_coef,
    input  logic [6:0]  req0_n,
    input  logic [6:0]  req1_n,
    output logic        req0_ack,
    output logic        req1_ack,
    output logic        eng_start,
    output logic [28:0] eng_coef,
    output logic [6:0]  eng_n,
    input  logic        eng_ready,
    input  logic        eng_done_tick,
    input  logic [31:0] eng_out,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_id,
    output logic        busy
);

    localparam int unsigned COEF_W = 29;
    localparam int unsigned N_W    = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMR_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic                prio_q;
    logic [TMR_W-1:0]    timer_q;
    logic [COEF_W-1:0]   eng_coef_q;
    logic [N_W-1:0]      eng_n_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_id_q;
    logic                eng_start_q;
    logic                rsp0_valid_q;
    logic                rsp1_valid_q;
    logic                rsp_err_q;
    logic                busy_q;

    logic                grant_c;
    logic                gnt_id_c;
    logic [TMR_W-1:0]    timer_d;
    logic                timeout_c;

    // Grant decision: a lone requester wins outright, otherwise prio breaks the tie.
    always_comb begin
        grant_c   = (state_q == IDLE) && eng_ready && (req0_valid || req1_valid);
        gnt_id_c  = (req0_valid && req1_valid) ? prio_q : req1_valid;
        timer_d   = timer_q + TMR_W'(1);
        timeout_c = (timer_d >= TMR_W'(TIMEOUT));
    end

    assign req0_ack = grant_c && !gnt_id_c;
    assign req1_ack = grant_c && gnt_id_c;

    // Timer counts completed WAIT cycles; the job aborts after TIMEOUT of them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            timer_q      <= '0;
            eng_coef_q   <= '0;
            eng_n_q      <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            eng_start_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            eng_start_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        eng_coef_q  <= gnt_id_c ? req1_coef : req0_coef;
                        eng_n_q     <= gnt_id_c ? req1_n : req0_n;
                        rsp_id_q    <= gnt_id_c;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_d;
                    if (eng_done_tick) begin
                        rsp_data_q   <= eng_out;
                        rsp0_valid_q <= !rsp_id_q;
                        rsp1_valid_q <= rsp_id_q;
                        state_q      <= RESP;
                    end else if (timeout_c) begin
                        rsp_err_q <= 1'b1;
                        prio_q    <= !rsp_id_q;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                RESP: begin
                    prio_q  <= !rsp_id_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eng_start  = eng_start_q;
    assign eng_coef   = eng_coef_q;
    assign eng_n      = eng_n_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_babbage_arbiter.sv
// Bench for babbage_arbiter: directed scenarios plus a randomized run against a
// job-timeline reference model (cycles since grant, done cycle, abort cycle).
module tb_babbage_arbiter;

    localparam int unsigned TO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [28:0] req0_coef, req1_coef;
    logic [6:0]  req0_n, req1_n;
    logic        req0_ack, req1_ack;
    logic        eng_start;
    logic [28:0] eng_coef;
    logic [6:0]  eng_n;
    logic        eng_ready;
    logic        eng_done_tick;
    logic [31:0] eng_out;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    babbage_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_coef(req0_coef), .req1_coef(req1_coef),
        .req0_n(req0_n), .req1_n(req1_n),
        .req0_ack(req0_ack), .req1_ack(req1_ack),
        .eng_start(eng_start), .eng_coef(eng_coef), .eng_n(eng_n),
        .eng_ready(eng_ready), .eng_done_tick(eng_done_tick), .eng_out(eng_out),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_coef = '0; req1_coef = '0; req0_n = '0; req1_n = '0;
        eng_ready = 1'b1; eng_done_tick = 1'b0; eng_out = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        quiet_inputs();
        tick();
        tick();
        #1;
        checks++;
        if ({busy, eng_start, rsp0_valid, rsp1_valid, rsp_err, rsp_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/start/r0/r1/err/id=%b required 000000",
                     {busy, eng_start, rsp0_valid, rsp1_valid, rsp_err, rsp_id});
        end
        checks++;
        if ({eng_coef, eng_n, rsp_data} !== 68'b0) begin
            errors++;
            $display("FAIL reset_data: got coef=%h n=%h data=%h required all zero", eng_coef, eng_n, rsp_data);
        end
        checks++;
        if ({req0_ack, req1_ack} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ack: got %b required 00", {req0_ack, req1_ack});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [28:0] c;
        logic [31:0] exp_d;
        c = 29'($urandom);
        exp_d = -32'sd1234;
        req0_valid = 1'b1; req0_n = 7'd5; req0_coef = c; eng_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ack, req1_ack} !== 2'b10) begin
            errors++;
            $display("FAIL single_ack: got %b required 10", {req0_ack, req1_ack});
        end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({eng_start, busy} !== 2'b11 || eng_n !== 7'd5 || eng_coef !== c) begin
            errors++;
            $display("FAIL single_start: got start=%b busy=%b n=%0d coef=%h required 1 1 5 %h",
                     eng_start, busy, eng_n, eng_coef, c);
        end
        tick();
        eng_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({eng_start, rsp0_valid, rsp_err, busy} !== 4'b0001) begin
                errors++;
                $display("FAIL single_wait: got start/r0/err/busy=%b required 0001",
                         {eng_start, rsp0_valid, rsp_err, busy});
            end
            tick();
        end
        eng_done_tick = 1'b1; eng_out = exp_d;
        tick();
        eng_done_tick = 1'b0; eng_ready = 1'b1;
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp_err, rsp_id} !== 4'b1000 || rsp_data !== exp_d) begin
            errors++;
            $display("FAIL single_rsp: got r0/r1/err/id=%b data=%0d required 1000 -1234",
                     {rsp0_valid, rsp1_valid, rsp_err, rsp_id}, $signed(rsp_data));
        end
        tick();
        #1;
        checks++;
        if ({rsp0_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_end: got r0/busy=%b required 00", {rsp0_valid, busy});
        end
        tick();
    endtask

    task automatic test_contention;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; eng_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit got;
            bit id;
            int waited;
            int d;
            logic [31:0] dat;
            got = 1'b0; id = 1'b0; waited = 0;
            while (!got && waited < 20) begin
                #1;
                if (req0_ack || req1_ack) begin
                    got = 1'b1;
                    id = req1_ack;
                end else begin
                    tick();
                    waited++;
                end
            end
            checks++;
            if (!got || id !== 1'(k % 2) || (req0_ack && req1_ack)) begin
                errors++;
                $display("FAIL contention_grant%0d: got granted=%b id=%b acks=%b required id %0d",
                         k, got, id, {req0_ack, req1_ack}, k % 2);
            end
            checks++;
            if (waited != 0) begin
                errors++;
                $display("FAIL contention_latency%0d: got %0d idle cycles required 0", k, waited);
            end
            tick();
            #1;
            checks++;
            if (eng_start !== 1'b1) begin
                errors++;
                $display("FAIL contention_start%0d: got %b required 1", k, eng_start);
            end
            tick();
            d = $urandom_range(0, 4);
            repeat (d) tick();
            dat = $urandom;
            eng_done_tick = 1'b1; eng_out = dat;
            tick();
            eng_done_tick = 1'b0;
            #1;
            checks++;
            if ({rsp0_valid, rsp1_valid} !== {!id, id} || rsp_id !== id || rsp_data !== dat) begin
                errors++;
                $display("FAIL contention_rsp%0d: got r0/r1=%b id=%b data=%h required %b %b %h",
                         k, {rsp0_valid, rsp1_valid}, rsp_id, rsp_data, {!id, id}, id, dat);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_timeout;
        int n;
        bit seen_rsp;
        bit seen_err;
        logic [31:0] old_d;
        old_d = rsp_data;
        req0_valid = 1'b1; req0_coef = 29'($urandom); eng_ready = 1'b1;
        #1;
        checks++;
        if (req0_ack !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ack: got %b required 1", req0_ack);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (eng_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_start: got %b required 1", eng_start);
        end
        n = 0; seen_rsp = 1'b0; seen_err = 1'b0;
        while (!seen_err && n < 30) begin
            tick();
            n++;
            #1;
            if (rsp0_valid || rsp1_valid) seen_rsp = 1'b1;
            if (rsp_err) seen_err = 1'b1;
        end
        checks++;
        if (!seen_err || n != int'(TO) + 1) begin
            errors++;
            $display("FAIL timeout_delay: got err=%b after %0d cycles required 1 after %0d", seen_err, n, TO + 1);
        end
        checks++;
        if (seen_rsp || busy !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== old_d) begin
            errors++;
            $display("FAIL timeout_state: got rsp_seen=%b busy=%b id=%b data=%h required 0 0 0 %h",
                     seen_rsp, busy, rsp_id, rsp_data, old_d);
        end
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b one cycle later required 0", rsp_err);
        end
        checks++;
        if ({req0_ack, req1_ack} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_prio: got acks %b required 01", {req0_ack, req1_ack});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        eng_done_tick = 1'b1; eng_out = $urandom;
        tick();
        eng_done_tick = 1'b0;
        #1;
        checks++;
        if (rsp1_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_followup: got r1=%b required 1", rsp1_valid);
        end
        tick();
    endtask

    task automatic test_coincidence;
        logic [31:0] dat;
        dat = $urandom;
        req1_valid = 1'b1; eng_ready = 1'b1;
        #1;
        checks++;
        if (req1_ack !== 1'b1) begin
            errors++;
            $display("FAIL coincide_ack: got %b required 1", req1_ack);
        end
        tick();
        req1_valid = 1'b0;
        tick();
        repeat (int'(TO) - 1) tick();
        eng_done_tick = 1'b1; eng_out = dat;
        tick();
        eng_done_tick = 1'b0;
        #1;
        checks++;
        if ({rsp1_valid, rsp_err} !== 2'b10 || rsp_data !== dat) begin
            errors++;
            $display("FAIL coincide_rsp: got r1/err=%b data=%h required 10 %h", {rsp1_valid, rsp_err}, rsp_data, dat);
        end
        tick();
        #1;
        checks++;
        if ({rsp1_valid, rsp_err, busy} !== 3'b000) begin
            errors++;
            $display("FAIL coincide_after: got r1/err/busy=%b required 000", {rsp1_valid, rsp_err, busy});
        end
        tick();
    endtask

    task automatic test_not_ready;
        eng_ready = 1'b0; req1_valid = 1'b1; req1_n = 7'd99;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({req0_ack, req1_ack, eng_start, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL notready_hold%0d: got ack0/ack1/start/busy=%b required 0000",
                         i, {req0_ack, req1_ack, eng_start, busy});
            end
            tick();
        end
        eng_ready = 1'b1;
        #1;
        checks++;
        if (req1_ack !== 1'b1) begin
            errors++;
            $display("FAIL notready_ack: got %b required 1", req1_ack);
        end
        tick();
        req1_valid = 1'b0;
        #1;
        checks++;
        if (eng_start !== 1'b1 || eng_n !== 7'd99) begin
            errors++;
            $display("FAIL notready_start: got start=%b n=%0d required 1 99", eng_start, eng_n);
        end
        tick();
        eng_done_tick = 1'b1;
        tick();
        eng_done_tick = 1'b0;
        #1;
        checks++;
        if (rsp1_valid !== 1'b1) begin
            errors++;
            $display("FAIL notready_rsp: got %b required 1", rsp1_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_job;
        req0_valid = 1'b1; req0_coef = 29'($urandom) | 29'd1; req0_n = 7'd77; eng_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, eng_start, rsp0_valid, rsp1_valid, rsp_err, rsp_id} !== 6'b0 ||
            {eng_coef, eng_n, rsp_data} !== 68'b0) begin
            errors++;
            $display("FAIL midreset_state: got busy/start/r0/r1/err/id=%b coef=%h n=%h data=%h required all zero",
                     {busy, eng_start, rsp0_valid, rsp1_valid, rsp_err, rsp_id}, eng_coef, eng_n, rsp_data);
        end
        eng_done_tick = 1'b1; eng_out = $urandom;
        tick();
        eng_done_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rsp0_valid, rsp1_valid, rsp_err, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL midreset_ignore%0d: got r0/r1/err/busy=%b required 0000",
                         i, {rsp0_valid, rsp1_valid, rsp_err, busy});
            end
            tick();
        end
    endtask

    // Reference: a job occupies cycles 'since grant' 1 (start), 2..TO+1 (waiting);
    // a done at since=k responds at k+1 and frees at k+2, otherwise abort at TO+2.
    task automatic test_random;
        bit          m_job, m_id, m_prio, m_err_now;
        int          since, done_at;
        logic [28:0] m_coef;
        logic [6:0]  m_n;
        logic [31:0] m_data;
        logic [7:0]  exp_v, got_v;
        bit          grant, gid, exp_rsp;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_job = 0; m_id = 0; m_prio = 0; m_err_now = 0; since = 0; done_at = 0;
        m_coef = '0; m_n = '0; m_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 9) < 3) req0_valid = !req0_valid;
            if ($urandom_range(0, 9) < 3) req1_valid = !req1_valid;
            req0_coef = 29'($urandom); req1_coef = 29'($urandom);
            req0_n = 7'($urandom); req1_n = 7'($urandom);
            eng_ready = ($urandom_range(0, 3) != 0);
            eng_done_tick = ($urandom_range(0, 99) < 12);
            eng_out = $urandom;
            reset = ($urandom_range(0, 299) != 0);
            #1;
            grant   = !m_job && eng_ready && (req0_valid || req1_valid);
            gid     = (req0_valid && req1_valid) ? m_prio : req1_valid;
            exp_rsp = m_job && done_at != 0 && since == done_at + 1;
            exp_v = {grant && !gid, grant && gid, m_job && since == 1,
                     exp_rsp && !m_id, exp_rsp && m_id, m_err_now, m_job, m_id};
            got_v = {req0_ack, req1_ack, eng_start, rsp0_valid, rsp1_valid, rsp_err, busy, rsp_id};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL rand_ctrl cycle %0d: got ack0/ack1/start/r0/r1/err/busy/id=%b required %b",
                         cyc, got_v, exp_v);
            end
            checks++;
            if (eng_coef !== m_coef || eng_n !== m_n || rsp_data !== m_data) begin
                errors++;
                $display("FAIL rand_data cycle %0d: got coef=%h n=%h data=%h required %h %h %h",
                         cyc, eng_coef, eng_n, rsp_data, m_coef, m_n, m_data);
            end
            m_err_now = 0;
            if (!reset) begin
                m_job = 0; m_id = 0; m_prio = 0; since = 0; done_at = 0;
                m_coef = '0; m_n = '0; m_data = '0;
            end else if (!m_job) begin
                if (grant) begin
                    m_job = 1; since = 1; done_at = 0; m_id = gid;
                    m_coef = gid ? req1_coef : req0_coef;
                    m_n = gid ? req1_n : req0_n;
                end
            end else begin
                if (since >= 2 && done_at == 0 && eng_done_tick) begin
                    done_at = since;
                    m_data = eng_out;
                end
                since++;
                if (done_at != 0 && since == done_at + 2) begin
                    m_job = 0; m_prio = !m_id;
                end else if (done_at == 0 && since == int'(TO) + 2) begin
                    m_job = 0; m_prio = !m_id; m_err_now = 1;
                end
            end
            tick();
        end
        reset = 1'b1;
        quiet_inputs();
    endtask

    initial begin
        reset = 1'b0;
        quiet_inputs();
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_coincidence();
        test_not_ready();
        test_reset_mid_job();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
